// File: rtl/cam_pkg.sv
// cam_pkg: definitions shared by the camera stream emulator and the capture
// path.
//   - MODE_* : test pattern select codes. Code 3 is reserved and is treated
//              as colour bars.
//   - RGB_*  : the eight RGB565 colour bar values, in left-to-right order.
//   - cam_state_e : frame sequencer states.
//   - bar_rgb() : bar index -> RGB565 value.
//   - cw(), imax() : helpers for sizing counters from parameters.
package cam_pkg;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } cam_state_e;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: combinational RGB565 pixel value for the test patterns.
//   mode_i  [1:0]  pattern select (MODE_*), reserved code gives colour bars
//   color_i [15:0] solid-fill colour
//   x_i     [XW]   pixel column within the line
//   y_i     [YW]   line within the frame
//   bar_i   [2:0]  colour bar index for column x_i
//   pix_o   [15:0] RGB565 pixel
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic [1:0]    mode_i,
    input  logic [15:0]   color_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [2:0]    bar_i,
    output logic [15:0]   pix_o
);

    always_comb begin
        if (mode_i == MODE_SOLID) begin
            pix_o = color_i;
        end else if (mode_i == MODE_COUNT) begin
            // Coordinates zero-extended or truncated to one byte each.
            pix_o = {8'(y_i), 8'(x_i)};
        end else begin
            pix_o = bar_rgb(bar_i);
        end
    end

endmodule

// File: rtl/cam_stream_tx.sv
// cam_stream_tx: emulates a parallel RGB565 camera output (VSYNC, HREF,
// pixel clock P, byte data D) carrying one of three test patterns.
//   clk        system clock
//   rst        asynchronous reset, active low
//   en         stream frames while high; low stops after the current frame
//   mode[1:0]  pattern select, latched at each frame start
//   color[15:0] solid colour, latched with mode
//   VSYNC      frame sync, high for V_SYNC line times
//   HREF       line valid, high for 2*H_ACTIVE P periods of each active line
//   P          pixel clock, clk/2, free running
//   D[7:0]     data byte, high byte of each pixel first, 00 outside HREF
//   busy       high from frame start to frame end
//   frame_done one-clk pulse at the end of each frame
// All stream outputs update only on the clk edge where P falls, so they are
// stable across every P rising edge.
module cam_stream_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 120,
    parameter int H_BLANK  = 20,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] color,
    output logic        VSYNC,
    output logic        HREF,
    output logic        P,
    output logic [7:0]  D,
    output logic        busy,
    output logic        frame_done
);

    localparam int LINE    = 2 * H_ACTIVE + H_BLANK;
    localparam int VMAX    = imax(imax(V_SYNC, V_BACK), imax(V_ACTIVE, V_FRONT));
    localparam int HW      = cw(LINE);
    localparam int VW      = cw(VMAX);
    localparam int XW      = cw(H_ACTIVE);
    localparam int YW      = cw(V_ACTIVE);
    localparam int BAR_PIX = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    cam_state_e      state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;   // P period within the line
    logic [VW-1:0]   vcnt_q, vcnt_d;   // line within the current state
    logic [1:0]      mode_q;
    logic [15:0]     color_q;
    logic            p_q, vsync_q, href_q, busy_q, done_q;
    logic [7:0]      d_q;

    logic            line_end, latch_d, frame_end_d, href_d;
    logic [VW-1:0]   last_line;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic [31:0]     bar_full;
    logic [2:0]      bar_d;
    logic [15:0]     pix_d;
    logic [7:0]      byte_d;

    always_comb begin
        case (state_q)
            ST_VSYNC:  last_line = VW'(V_SYNC - 1);
            ST_VBACK:  last_line = VW'(V_BACK - 1);
            ST_ACTIVE: last_line = VW'(V_ACTIVE - 1);
            ST_VFRONT: last_line = VW'(V_FRONT - 1);
            default:   last_line = '0;
        endcase
    end

    // Sequencer next state for the coming P period. Only consumed on fall
    // edges of P.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        latch_d     = 1'b0;
        frame_end_d = 1'b0;
        line_end    = (hcnt_q == HW'(LINE - 1));
        if (state_q == ST_IDLE) begin
            if (en) begin
                state_d = ST_VSYNC;
                latch_d = 1'b1;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                if (vcnt_q == last_line) begin
                    vcnt_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        default: begin
                            frame_end_d = 1'b1;
                            latch_d     = en;
                            state_d     = en ? ST_VSYNC : ST_IDLE;
                        end
                    endcase
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end
        end
    end

    // Pixel for the coming period is computed from the next-state counters,
    // so the registered D byte lines up with HREF with no extra delay.
    always_comb begin
        href_d   = (state_d == ST_ACTIVE) &&
                   ({1'b0, hcnt_d} < (HW + 1)'(2 * H_ACTIVE));
        x_d      = XW'(hcnt_d >> 1);
        y_d      = YW'(vcnt_d);
        bar_full = 32'(x_d) / 32'(BAR_PIX);
        // Columns past the last full bar stay in bar 7.
        bar_d    = (bar_full > 32'd7) ? 3'd7 : 3'(bar_full);
    end

    cam_pattern_gen #(
        .XW(XW),
        .YW(YW)
    ) u_pattern (
        .mode_i  (mode_q),
        .color_i (color_q),
        .x_i     (x_d),
        .y_i     (y_d),
        .bar_i   (bar_d),
        .pix_o   (pix_d)
    );

    assign byte_d = hcnt_d[0] ? pix_d[7:0] : pix_d[15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            mode_q  <= '0;
            color_q <= '0;
            p_q     <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            p_q    <= ~p_q;
            done_q <= 1'b0;
            // p_q high here means P falls on this edge.
            if (p_q) begin
                state_q <= state_d;
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                if (latch_d) begin
                    mode_q  <= mode;
                    color_q <= color;
                end
                vsync_q <= (state_d == ST_VSYNC);
                href_q  <= href_d;
                d_q     <= href_d ? byte_d : 8'h00;
                busy_q  <= (state_d != ST_IDLE);
                done_q  <= frame_end_d;
            end
        end
    end

    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign P          = p_q;
    assign D          = d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_cam_stream_tx.sv
module tb_cam_stream_tx;
    import cam_pkg::*;

    localparam int L = 20;  // 2*8 + 4 P periods per line

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] color = 16'h0000;
    logic        VSYNC, HREF, P, busy, frame_done;
    logic [7:0]  D;

    cam_stream_tx #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .color(color),
        .VSYNC(VSYNC), .HREF(HREF), .P(P), .D(D),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: samples on every P rising edge.
    logic       pp = 1'b0, pv = 1'b0, ph = 1'b0, hp = 1'b0, vp = 1'b0;
    logic [7:0] pd = 8'h00;
    int per = 0, fd_cnt = 0, stab_err = 0, blank_nz = 0, hrun = 0;
    logic [7:0] bytes_q[$];
    int runs_q[$];
    int vs_per_q[$];
    int hr_per_q[$];

    always @(negedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (!rst) begin
            hp   <= 1'b0;
            vp   <= 1'b0;
            hrun <= 0;
        end else if (P && !pp) begin
            per <= per + 1;
            if (VSYNC !== pv || HREF !== ph || D !== pd) stab_err <= stab_err + 1;
            if (VSYNC && !vp) vs_per_q.push_back(per + 1);
            if (HREF) begin
                bytes_q.push_back(D);
                if (!hp) hr_per_q.push_back(per + 1);
                hrun <= hrun + 1;
            end else begin
                if (D != 8'h00) blank_nz <= blank_nz + 1;
                if (hp) begin
                    runs_q.push_back(hrun);
                    hrun <= 0;
                end
            end
            hp <= HREF;
            vp <= VSYNC;
        end
        pp <= P;
        pv <= VSYNC;
        ph <= HREF;
        pd <= D;
    end

    // Bounded wait until a monitor count reaches n: 0 = VSYNC rises,
    // 1 = HREF rises, 2 = frame_done pulses.
    function automatic int cnt(input int which);
        if (which == 0) return vs_per_q.size();
        if (which == 1) return hr_per_q.size();
        return fd_cnt;
    endfunction

    task automatic wait_cnt(input int which, input int n, input string tag);
        int k = 0;
        while (cnt(which) < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(cnt(which) >= n), 1);
    endtask

    int b0, r0, v0, h0, f0, bn0, p0;

    task automatic snap();
        b0 = bytes_q.size(); r0 = runs_q.size(); v0 = vs_per_q.size();
        h0 = hr_per_q.size(); f0 = fd_cnt; bn0 = blank_nz; p0 = per;
    endtask

    logic [7:0] bars_exp [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vsync", int'(VSYNC), 0);
        chk("rst_href", int'(HREF), 0);
        chk("rst_p", int'(P), 0);
        chk("rst_d", int'(D), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);

        // A: solid magenta, single frame
        mode = MODE_SOLID; color = 16'hF81F; en = 1'b1;
        snap();
        @(negedge clk) rst = 1'b1;
        wait_cnt(0, v0 + 1, "A_vs_wait");
        en = 1'b0;
        wait_cnt(2, f0 + 1, "A_fd_wait");
        @(negedge clk);
        chk("A_vs_first", vs_per_q[v0] - p0, 2);
        chk("A_busy_low", int'(busy), 0);
        chk("A_runs", runs_q.size() - r0, 4);
        for (int i = 0; i < 4; i++) chk("A_runlen", runs_q[r0 + i], 16);
        chk("A_nbytes", bytes_q.size() - b0, 64);
        e = 0;
        for (int i = 0; i < 64; i++)
            if (bytes_q[b0 + i] != ((i % 2 == 0) ? 8'hF8 : 8'h1F)) e++;
        chk("A_bytes", e, 0);
        chk("A_href_ofs", hr_per_q[h0] - vs_per_q[v0], 2 * L);
        chk("A_fd_cnt", fd_cnt - f0, 1);
        chk("A_blank_d", blank_nz - bn0, 0);
        snap();
        repeat (100) @(negedge clk);
        chk("A_idle_vs", vs_per_q.size() - v0, 0);
        chk("A_p_free", per - p0, 50);

        // B: bars back-to-back with a mid-frame mode change for frame 2
        mode = MODE_BARS; en = 1'b1;
        snap();
        wait_cnt(0, v0 + 1, "B_vs_wait");
        mode = MODE_SOLID; color = 16'h001F;
        wait_cnt(2, f0 + 1, "B_fd1_wait");
        @(negedge clk);
        chk("B_busy_held", int'(busy), 1);
        wait_cnt(0, v0 + 2, "B_vs2_wait");
        en = 1'b0;
        wait_cnt(2, f0 + 2, "B_fd2_wait");
        chk("B_period", vs_per_q[v0 + 1] - vs_per_q[v0], 7 * L);
        chk("B_nbytes", bytes_q.size() - b0, 128);
        e = 0;
        for (int i = 0; i < 16; i++) begin
            if (bytes_q[b0 + i] != bars_exp[i]) e++;
            if (bytes_q[b0 + 48 + i] != bars_exp[i]) e++;
        end
        chk("B_bars", e, 0);
        chk("B_latch_hi", int'(bytes_q[b0 + 64]), 8'h00);
        chk("B_latch_lo", int'(bytes_q[b0 + 65]), 8'h1F);

        // C: coordinate counter
        mode = MODE_COUNT; en = 1'b1;
        snap();
        wait_cnt(0, v0 + 1, "C_vs_wait");
        en = 1'b0;
        wait_cnt(2, f0 + 1, "C_fd_wait");
        chk("C_y2x5_hi", int'(bytes_q[b0 + 42]), 8'h02);
        chk("C_y2x5_lo", int'(bytes_q[b0 + 43]), 8'h05);
        e = 0;
        for (int i = 0; i < 64; i++)
            if (int'(bytes_q[b0 + i]) != ((i % 2 == 0) ? i / 16 : (i % 16) / 2)) e++;
        chk("C_all", e, 0);
        chk("C_blank_d", blank_nz - bn0, 0);

        // D: reserved mode, en dropped during ACTIVE
        mode = 2'd3; en = 1'b1;
        snap();
        wait_cnt(1, h0 + 2, "D_hr_wait");
        en = 1'b0;
        wait_cnt(2, f0 + 1, "D_fd_wait");
        @(negedge clk);
        chk("D_runs", runs_q.size() - r0, 4);
        chk("D_nbytes", bytes_q.size() - b0, 64);
        e = 0;
        for (int i = 0; i < 16; i++) if (bytes_q[b0 + i] != bars_exp[i]) e++;
        chk("D_bars", e, 0);
        chk("D_busy_low", int'(busy), 0);
        snap();
        repeat (100) @(negedge clk);
        chk("D_no_vs", vs_per_q.size() - v0, 0);
        chk("D_p_free", per - p0, 50);
        chk("D_fd_once", fd_cnt - f0, 0);

        // E: reset mid-line, then a fresh frame with a new colour
        mode = MODE_SOLID; color = 16'hF81F; en = 1'b1;
        snap();
        wait_cnt(1, h0 + 2, "E_hr_wait");
        repeat (5) @(negedge clk);
        chk("E_pre_href", int'(HREF), 1);
        #2 rst = 1'b0;
        #1;
        chk("E_rst_href", int'(HREF), 0);
        chk("E_rst_d", int'(D), 0);
        chk("E_rst_p", int'(P), 0);
        chk("E_rst_busy", int'(busy), 0);
        chk("E_rst_vsync", int'(VSYNC), 0);
        color = 16'h07E0;
        repeat (3) @(negedge clk);
        snap();
        rst = 1'b1;
        wait_cnt(0, v0 + 1, "E_vs_wait");
        en = 1'b0;
        wait_cnt(2, f0 + 1, "E_fd_wait");
        chk("E_vs_first", vs_per_q[v0] - p0, 2);
        chk("E_runs", runs_q.size() - r0, 4);
        chk("E_nbytes", bytes_q.size() - b0, 64);
        e = 0;
        for (int i = 0; i < 64; i++)
            if (bytes_q[b0 + i] != ((i % 2 == 0) ? 8'h07 : 8'hE0)) e++;
        chk("E_bytes", e, 0);

        chk("stable_on_p_rise", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
